serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in on a start strobe and adds them LSB-first, one bit per clock. Each bit goes through a full-adder cell built from two `halfadder` instances, with a registered carry between bits. The block sits downstream of the `halfadder` primitive and consumes its sum and carry outputs every cycle. It trades WIDTH+1 cycles of latency for a single adder cell, for area-constrained arithmetic paths.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`, input, 1: request to begin an addition; accepted only in IDLE.
- `a`, input, WIDTH: operand A; sampled on the accepting edge only.
- `b`, input, WIDTH: operand B; sampled on the accepting edge only.
- `cin`, input, 1: carry-in; sampled on the accepting edge only.
- `busy`, output, 1: high while in RUN or DONE.
- `done`, output, 1: one-cycle pulse; `sum` and `cout` are valid.
- `sum`, output, WIDTH: result; held stable from `done` until the next accept.
- `cout`, output, 1: final carry-out; held together with `sum`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN:
  - Trigger: `start`=1 on an edge.
  - Load shift registers `sa`=`a` and `sb`=`b`.
  - Load carry register `c`=`cin`.
  - Clear bit counter `cnt`=0.
  - Clear `sum` to 0.
- RUN, each edge:
  - Full-adder cell inputs: `sa[0]`, `sb[0]`, `c`.
  - `sa` and `sb` shift right by one; the MSB fills with 0.
  - The cell's sum bit shifts into `sum` from the MSB side (`sum` shifts right).
  - `c` takes the cell's carry-out.
  - `cnt` increments.
- RUN → DONE: on the edge where `cnt`==WIDTH-1. After that edge `sum` holds all WIDTH bits and `cout`=`c`.
- DONE → IDLE: unconditionally on the next edge.
- `start` in RUN or DONE is ignored: no queuing and no operand resample.
- Full-adder cell arithmetic:
  - s = `sa0` ^ `sb0` ^ `c`.
  - co = (`sa0` & `sb0`) | ((`sa0` ^ `sb0`) & `c`).
  - Realised as two half adders plus an OR.
- Result: {`cout`,`sum`} = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1). Overflow is reported via `cout` only.
- Counter width: $clog2(WIDTH), minimum 1 bit.
- WIDTH=1: RUN lasts exactly one cycle.
- Reset (`rst_n`=0 on an edge, in any state including mid-RUN):
  - State goes to IDLE.
  - `cnt`, `c`, `sa`, `sb`, `sum`, `cout`, `busy`, `done` all go to 0.
  - The partial result is discarded.
- Reset has priority over `start` on the same edge.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0.
- Accepting edge E (IDLE, `start`=1):
  - `busy`=1 from E.
  - `done`=1 for exactly the cycle after edge E+WIDTH.
  - State returns to IDLE after edge E+WIDTH+1.
- Latency: `done` rises WIDTH edges after accept.
- Throughput: one operation per WIDTH+2 cycles when `start` is held high.
- `sum` and `cout` are registered outputs with no combinational path from any input.
- `sum` and `cout` are not valid until `done`; intermediate values during RUN are don't-care to consumers.

## Structure
- Shared package `serial_adder_pkg`:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter-width helper constant.
- Sub-module `fa_cell`: combinational full adder built from two `halfadder` instances plus an OR gate; instantiated once.
- Top level contains the FSM, shift registers, carry flop, counter and output registers.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0 → `done` 8 edges after accept; `sum`=0x00, `cout`=0.
- a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1; `busy` high for 9 cycles.
- a=0x5A, b=0xA5, cin=1 → `sum`=0x00, `cout`=1. Also check a=0x3C, b=0x42, cin=0 → `sum`=0x7E, `cout`=0.
- Pulse `start` with new operands (0x11, 0x22) mid-RUN → ignored; first result unchanged and exactly one `done` pulse.
- Assert `rst_n`=0 at RUN cycle 4 → next cycle all outputs 0 and state IDLE; a fresh start then yields the correct sum.
- Hold `start`=1 with random operands over 1000 operations → `done` every 10 cycles; every result matches the reference model a+b+cin. Repeat with WIDTH=1 (`done` every 3 cycles).

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
//
// Purpose: state encoding for the serial_adder FSM and the bit-counter width helper.
// Ports:   none (package).

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must index WIDTH bits; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle between a requester and serial_adder
//
// Purpose: groups the start strobe, operands and result signals of one serial adder.
// Signals:
//   start, a, b, cin : requester -> adder (sampled only on the accepting edge)
//   busy, done       : adder -> requester status
//   sum, cout        : adder -> requester result, valid while done is high

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/halfadder.sv
// rtl/halfadder.sv - single-bit half adder primitive
//
// Purpose: s = a ^ b, c = a & b.
// Ports:
//   a_i, b_i : addend bits
//   s_o      : sum bit
//   c_o      : carry bit

module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - combinational full adder built from two half adders
//
// Purpose: one full-adder cell, reused every cycle by serial_adder.
// Ports:
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   co_o     : carry out

module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic p; // propagate: a ^ b
  logic g; // generate:  a & b
  logic t; // carry propagated through from c_i

  halfadder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (p),
    .c_o (g)
  );

  halfadder u_ha1 (
    .a_i (p),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (t)
  );

  assign co_o = g | t;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first ripple adder using a single full-adder cell
//
// Purpose: computes {cout, sum} = a + b + cin one bit per clock; done pulses WIDTH
//          edges after the accepting edge.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_adder_if slave (start/a/b/cin in, busy/done/sum/cout out)

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  fa_cell u_fa (
    .a_i  (sa_q[0]),
    .b_i  (sb_q[0]),
    .c_i  (c_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          sa_d    = bus.a;
          sb_d    = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end

      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
        sum_d = sum_q >> 1;
        sum_d[WIDTH-1] = fa_s;
        c_d   = fa_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          cout_d  = fa_co;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status is decoded from the state register only, so no input reaches an output.
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One WIDTH=8 operation from IDLE; optionally pokes start with new operands mid-RUN.
  // Returns the captured result, done latency (edges after accept), busy cycle count
  // and the number of done pulses seen in a fixed 12-edge window.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input bit poke, output logic [7:0] s, output logic co,
                       output int lat, output int bcnt, output int ndone);
    bus8.a = a;
    bus8.b = b;
    bus8.cin = ci;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bcnt  = bus8.busy ? 1 : 0;
    lat   = 0;
    ndone = 0;
    s     = 8'hxx;
    co    = 1'bx;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (poke && i == 3) begin
        bus8.start = 1'b1;
        bus8.a = 8'h11;
        bus8.b = 8'h22;
        bus8.cin = 1'b0;
      end else begin
        bus8.start = 1'b0;
      end
      if (bus8.busy) bcnt++;
      if (bus8.done) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          s   = bus8.sum;
          co  = bus8.cout;
        end
      end
    end
    check("hold_sum", bus8.sum, s);
    check("hold_cout", bus8.cout, co);
  endtask

  // start held high with fresh random operands every cycle; accepts are expected
  // every WIDTH+2 edges starting with the first edge, results equal a+b+cin.
  task automatic random_run(input int w, input int nops);
    int p, mask, ra, rb, rc, act, last_done;
    bit d;
    int q[$];
    p = w + 2;
    mask = (1 << w) - 1;
    last_done = -1;
    for (int idx = 0; idx < nops * p; idx++) begin
      ra = $urandom & mask;
      rb = $urandom & mask;
      rc = $urandom & 1;
      if (w == 8) begin
        bus8.start = 1'b1; bus8.a = ra[7:0]; bus8.b = rb[7:0]; bus8.cin = rc[0];
      end else begin
        bus1.start = 1'b1; bus1.a = ra[0]; bus1.b = rb[0]; bus1.cin = rc[0];
      end
      if (idx % p == 0) q.push_back(ra + rb + rc);
      @(posedge clk); #1;
      if (w == 8) begin
        d = bus8.done; act = {23'd0, bus8.cout, bus8.sum};
      end else begin
        d = bus1.done; act = {30'd0, bus1.cout, bus1.sum};
      end
      if (d || (idx % p == w)) check("done_timing", d, (idx % p == w));
      if (d) begin
        if (q.size() == 0) check("result_pending", 0, 1);
        else check("result", act, q.pop_front());
        if (last_done >= 0) check("done_period", idx - last_done, p);
        last_done = idx;
      end
    end
    bus8.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    logic       co;
    int         lat, bcnt, nd;

    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'h5A, b: 8'hA5, cin: 1'b1, sum: 8'h00, cout: 1'b1};
    vecs[3] = '{a: 8'h3C, b: 8'h42, cin: 1'b0, sum: 8'h7E, cout: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, sum: 8'h47, cout: 1'b0};

    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", bus8.busy, 0);
    check("rst_done8", bus8.done, 0);
    check("rst_sum8",  bus8.sum,  0);
    check("rst_cout8", bus8.cout, 0);
    check("rst_busy1", bus1.busy, 0);
    check("rst_done1", bus1.done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single operations.
    for (int k = 0; k < 7; k++) begin
      do_op(vecs[k].a, vecs[k].b, vecs[k].cin, 1'b0, s, co, lat, bcnt, nd);
      check("vec_sum",  s,  vecs[k].sum);
      check("vec_cout", co, vecs[k].cout);
      check("vec_latency", lat, 8);
      check("vec_busy_cycles", bcnt, 9);
      check("vec_done_pulses", nd, 1);
    end

    // start pulsed mid-RUN with new operands must be ignored.
    do_op(8'h5A, 8'hA5, 1'b1, 1'b1, s, co, lat, bcnt, nd);
    check("poke_sum", s, 8'h00);
    check("poke_cout", co, 1'b1);
    check("poke_latency", lat, 8);
    check("poke_done_pulses", nd, 1);

    // Reset at RUN cycle 4 discards the partial result.
    bus8.a = 8'h3C; bus8.b = 8'h42; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_busy", bus8.busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", bus8.busy, 0);
    check("midrst_done", bus8.done, 0);
    check("midrst_sum",  bus8.sum,  0);
    check("midrst_cout", bus8.cout, 0);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) nd++;
    end
    check("midrst_stays_idle", nd, 0);
    do_op(8'h3C, 8'h42, 1'b0, 1'b0, s, co, lat, bcnt, nd);
    check("after_rst_sum", s, 8'h7E);
    check("after_rst_cout", co, 1'b0);
    check("after_rst_latency", lat, 8);

    // Reset has priority over start on the same edge.
    rst_n = 1'b0;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    check("rst_vs_start_busy", bus8.busy, 0);
    bus8.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    random_run(8, 1000);
    @(posedge clk); #1;
    random_run(1, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
